seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled on the clk rising edge.
REQ-005 The block SHALL have port a, input, WIDTH bits: multiplicand.
REQ-006 The block SHALL have port b, input, WIDTH bits: multiplier.
REQ-007 The block SHALL have port is_signed, input, 1 bit: selects two's-complement operands, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking product as updated.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits: the result of the last completed operation.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and FINISH.
REQ-012 In IDLE, start=1 SHALL capture a, b and is_signed, load the accumulator with {WIDTH+1 zeros, |b|}, clear the counter and move to RUN.
REQ-013 The RUN state SHALL last exactly WIDTH cycles; each cycle, if acc[0]=1 then acc upper (WIDTH+1) bits += |a|, then acc shifts right by 1 with zero fill.
REQ-014 After the last RUN cycle the FSM SHALL enter FINISH for one cycle: product registered and done=1, then return to IDLE.
REQ-015 Latency SHALL be fixed: start sampled at edge k gives done high and product valid in the cycle after edge k+WIDTH+1.
REQ-016 Latency SHALL be independent of operand values; there is no early termination.
REQ-017 busy SHALL be 1 in RUN and FINISH and 0 in IDLE.
REQ-018 start SHALL be ignored while busy=1; a new start is accepted in the cycle after done.
REQ-019 product SHALL hold its value between completions and change only in the done cycle.
REQ-020 The unsigned result SHALL be exact for all inputs; the maximum (2^WIDTH-1)^2 fits in 2*WIDTH bits without overflow.
REQ-021 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap during RUN.

Reset
REQ-022 reset_n=0 SHALL immediately force state=IDLE, busy=0, done=0, product=0, accumulator=0 and counter=0, regardless of clk.
REQ-023 A reset asserted mid-operation SHALL abort the operation; no done is generated for it.
REQ-024 After reset_n deasserts, the first start SHALL be accepted on the first rising edge at which reset_n=1.

Configuration
REQ-025 With macro SEQ_MULT_SIGNED_EN defined, is_signed=1 SHALL make the block use |a| and |b| and negate the result in FINISH when a[MSB]^b[MSB]=1; latency is unchanged.
REQ-026 In signed mode, the operand -2^(WIDTH-1) SHALL be handled correctly; its magnitude is treated as a WIDTH-bit unsigned value.
REQ-027 Without SEQ_MULT_SIGNED_EN, is_signed SHALL be ignored (port kept, unconnected internally) and all operations SHALL be unsigned.

Structure
REQ-028 Package seq_mult_pkg SHALL hold the state enum (IDLE, RUN, FINISH) and the counter-width function.
REQ-029 The accumulate/shift datapath SHALL be sub-module seq_mult_dp; the FSM, counter and sign handling stay in seq_multiplier.

Verification (WIDTH=8)
REQ-030 Scenario: a=13, b=11, unsigned -> done in the cycle after edge k+9; product=143; busy high for 9 cycles.
REQ-031 Scenario: a=255, b=255 -> product=65025; a=0, b=200 -> product=0 with identical latency.
REQ-032 Scenario (SIGNED_EN): a=-3, b=5 -> product=0xFFF1; a=-128, b=-128 -> product=16384; a=-128, b=127 -> 0xC080.
REQ-033 Scenario: start pulsed with new operands at RUN cycle 3 -> ignored; only the original product is produced, with a single done.
REQ-034 Scenario: reset_n low at RUN cycle 4 -> outputs 0 asynchronously; no done; a following start gives the correct result.
REQ-035 Scenario: back-to-back start in the cycle after each done for 100 random operand pairs -> every product matches the reference multiply.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared FSM state encoding and counter sizing for seq_multiplier.
//   state_t   : IDLE / RUN / FINISH
//   cnt_width : bits needed to count 0..WIDTH
package seq_mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// seq_mult_dp: shift-and-add datapath, one partial product per step.
//   clk, reset_n   : clock, asynchronous active-low reset
//   load           : capture mag_a and seed the accumulator with mag_b
//   step           : add mag_a to the upper half if acc[0], then shift right
//   mag_a, mag_b   : unsigned operand magnitudes (WIDTH bits)
//   prod           : low 2*WIDTH bits of the accumulator
module seq_mult_dp #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mag_a,
    input  logic [WIDTH-1:0]   mag_b,
    output logic [2*WIDTH-1:0] prod
);

    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] ma;
    logic [WIDTH:0]   sum;

    // Upper part stays below 2^WIDTH before each add, so WIDTH+1 bits never overflow.
    assign sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, ma} : '0);
    assign prod = acc[2*WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            ma  <= '0;
        end else if (load) begin
            acc <= {{(WIDTH+1){1'b0}}, mag_b};
            ma  <= mag_a;
        end else if (step) begin
            acc <= {1'b0, sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: fixed-latency sequential multiplier (WIDTH RUN cycles + FINISH).
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : request, sampled in IDLE only
//   a, b         : operands (WIDTH bits)
//   is_signed    : two's-complement operands when SEQ_MULT_SIGNED_EN is defined,
//                  otherwise ignored
//   busy         : high in RUN and FINISH
//   done         : one-cycle pulse when product updates
//   product      : last completed result (2*WIDTH bits)
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    import seq_mult_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    state_t               state, nxt;
    logic [CW-1:0]        cnt;
    logic                 neg, neg_in, load, step, last;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   dp_prod;

`ifdef SEQ_MULT_SIGNED_EN
    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
    assign mag_a  = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b  = (is_signed && b[WIDTH-1]) ? -b : b;
    assign neg_in = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign mag_a  = a;
    assign mag_b  = b;
    assign neg_in = 1'b0;
`endif

    always_comb begin
        load = (state == IDLE) && start;
        step = (state == RUN);
        last = step && (cnt == CW'(WIDTH - 1));
        nxt  = load ? RUN : last ? FINISH : (state == FINISH) ? IDLE : state;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state <= nxt;
            done  <= (state == FINISH);
            if (load) begin
                cnt <= '0;
                neg <= neg_in;
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
            if (state == FINISH)
                product <= neg ? -dp_prod : dp_prod;
        end
    end

    seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .step    (step),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .prod    (dp_prod)
    );

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and back-to-back checks of seq_multiplier at WIDTH=8.
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           is_signed = 1'b0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    // Called just after a negedge: requests one operation and follows it until
    // the cycle after done. m counts cycles after the edge that samples start.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sg,
                          output logic [2*W-1:0] p, output int lat, output int bcnt,
                          output int dcnt, output logic held);
        logic [2*W-1:0] p0;
        p0 = product;
        a = ia; b = ib; is_signed = sg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; bcnt = 0; dcnt = 0; held = 1'b1;
        for (int m = 0; m < 40 && (lat < 0 || m <= lat + 1); m++) begin
            if (m > 0) @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) lat = m;
            end
            if (lat < 0 && product !== p0) held = 1'b0;
        end
        p = product;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_cmp++; if (product !== 16'h0) begin n_err++; $display("FAIL reset_product: got %0d expected 0", product); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [2*W-1:0] p; int lat, bc, dc; logic held;
        run_op(8'd13, 8'd11, 1'b0, p, lat, bc, dc, held);
        n_cmp++; if (p !== 16'd143) begin n_err++; $display("FAIL basic_product: got %0d expected 143", p); end
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL basic_latency: got %0d expected 9", lat); end
        n_cmp++; if (bc !== 9) begin n_err++; $display("FAIL basic_busy_cycles: got %0d expected 9", bc); end
        n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d expected 1", dc); end
        n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL basic_product_hold: got %0b expected 1", held); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_extremes();
        logic [2*W-1:0] p; int lat, bc, dc; logic held;
        run_op(8'd255, 8'd255, 1'b0, p, lat, bc, dc, held);
        n_cmp++; if (p !== 16'd65025) begin n_err++; $display("FAIL max_product: got %0d expected 65025", p); end
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL max_latency: got %0d expected 9", lat); end
        run_op(8'd0, 8'd200, 1'b0, p, lat, bc, dc, held);
        n_cmp++; if (p !== 16'd0) begin n_err++; $display("FAIL zero_product: got %0d expected 0", p); end
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL zero_latency: got %0d expected 9", lat); end
        run_op(8'd1, 8'd1, 1'b0, p, lat, bc, dc, held);
        n_cmp++; if (p !== 16'd1) begin n_err++; $display("FAIL one_product: got %0d expected 1", p); end
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed();
        logic [2*W-1:0] p; int lat, bc, dc; logic held;
        run_op(8'hFD, 8'd5, 1'b1, p, lat, bc, dc, held);
        n_cmp++; if (p !== 16'hFFF1) begin n_err++; $display("FAIL signed_m3x5: got %0h expected fff1", p); end
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL signed_latency: got %0d expected 9", lat); end
        run_op(8'h80, 8'h80, 1'b1, p, lat, bc, dc, held);
        n_cmp++; if (p !== 16'd16384) begin n_err++; $display("FAIL signed_min_sq: got %0d expected 16384", p); end
        run_op(8'h80, 8'd127, 1'b1, p, lat, bc, dc, held);
        n_cmp++; if (p !== 16'hC080) begin n_err++; $display("FAIL signed_min_max: got %0h expected c080", p); end
        run_op(8'hFD, 8'd5, 1'b0, p, lat, bc, dc, held);
        n_cmp++; if (p !== 16'd1265) begin n_err++; $display("FAIL signed_off: got %0d expected 1265", p); end
    endtask
`else
    task automatic test_signed();
        logic [2*W-1:0] p; int lat, bc, dc; logic held;
        run_op(8'hFD, 8'd5, 1'b1, p, lat, bc, dc, held);
        n_cmp++; if (p !== 16'd1265) begin n_err++; $display("FAIL unsigned_is_signed_ignored: got %0d expected 1265", p); end
        run_op(8'h80, 8'h80, 1'b1, p, lat, bc, dc, held);
        n_cmp++; if (p !== 16'd16384) begin n_err++; $display("FAIL unsigned_128sq: got %0d expected 16384", p); end
    endtask
`endif

    task automatic test_ignore_start();
        int dc; logic seen_busy_after;
        a = 8'd7; b = 8'd9; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = 0; seen_busy_after = 1'b0;
        for (int m = 0; m < 30; m++) begin
            if (m > 0) @(negedge clk);
            if (m == 2) begin a = 8'd100; b = 8'd100; start = 1'b1; end
            if (m == 3) start = 1'b0;
            if (done) dc++;
            if (m > 10 && busy) seen_busy_after = 1'b1;
        end
        n_cmp++; if (product !== 16'd63) begin n_err++; $display("FAIL ignore_product: got %0d expected 63", product); end
        n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL ignore_done_count: got %0d expected 1", dc); end
        n_cmp++; if (seen_busy_after !== 1'b0) begin n_err++; $display("FAIL ignore_no_restart: got %0b expected 0", seen_busy_after); end
    endtask

    task automatic test_mid_reset();
        logic [2*W-1:0] p; int lat, bc, dc; logic held;
        a = 8'd200; b = 8'd3; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %0b expected 0", done); end
        n_cmp++; if (product !== 16'd0) begin n_err++; $display("FAIL midrst_product: got %0d expected 0", product); end
        @(negedge clk);
        reset_n = 1'b1;
        dc = 0;
        repeat (14) begin
            @(negedge clk);
            if (done || busy) dc++;
        end
        n_cmp++; if (dc !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d activity cycles expected 0", dc); end
        run_op(8'd12, 8'd12, 1'b0, p, lat, bc, dc, held);
        n_cmp++; if (p !== 16'd144) begin n_err++; $display("FAIL midrst_after_product: got %0d expected 144", p); end
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL midrst_after_latency: got %0d expected 9", lat); end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] p, exp; logic [W-1:0] ra, rb; int lat, bc, dc; logic held;
        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            exp = 16'(ra) * 16'(rb);
            run_op(ra, rb, 1'b0, p, lat, bc, dc, held);
            n_cmp++; if (p !== exp) begin n_err++; $display("FAIL b2b_product[%0d] %0d*%0d: got %0d expected %0d", i, ra, rb, p, exp); end
            n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d expected 9", i, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_signed();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
